// File: rtl/imem_fetch_buffer.sv
// rtl/imem_fetch_buffer.sv - instruction fetch front end: 2-entry tagged word buffer
// with demand fill over a req/gnt/rvalid port and optional sequential next-word prefetch.
module imem_fetch_buffer #(
    parameter bit PREFETCH_EN = 1'b1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      imem_addr,
    output logic [31:0]      imem_data,
    output logic             imem_valid,
    input  logic             flush,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [31:0]      mem_rdata,
    output logic [CNT_W-1:0] miss_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ_D  = 3'd1,
        S_WAIT_D = 3'd2,
        S_REQ_P  = 3'd3,
        S_WAIT_P = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_v;
    logic [29:0]      r_tag [2];
    logic [31:0]      r_data [2];
    logic             r_lru;
    logic             r_drop;
    logic [31:0]      r_addr;
    logic [CNT_W-1:0] r_miss_cnt;

    logic [1:0]       w_hit;
    logic             w_hit_any;
    logic             w_in_req;
    logic             w_in_wait;
    logic             w_fill;
    logic             w_tgt;
    logic             w_pf_present;
    logic             w_pf_go;
    logic             w_issue;
    logic             w_set_drop;
    logic [31:0]      w_nxt_addr;

    assign w_hit[0]   = r_v[0] && (r_tag[0] == imem_addr[31:2]);
    assign w_hit[1]   = r_v[1] && (r_tag[1] == imem_addr[31:2]);
    assign w_hit_any  = |w_hit;
    assign imem_valid = w_hit_any;
    assign imem_data  = w_hit[0] ? r_data[0] : (w_hit[1] ? r_data[1] : 32'd0);
    assign miss_cnt   = r_miss_cnt;

    assign w_in_req   = (r_state == S_REQ_D) || (r_state == S_REQ_P);
    assign w_in_wait  = (r_state == S_WAIT_D) || (r_state == S_WAIT_P);
    assign w_fill     = w_in_wait && mem_rvalid && !flush;
    assign w_issue    = (r_state == S_IDLE) && !flush && !r_drop && !w_hit_any;
    assign w_set_drop = flush && ((w_in_req && mem_gnt) || (w_in_wait && !mem_rvalid));
    assign w_nxt_addr = r_addr + 32'd4;

    // Existing tag wins, then LRU, but never evict the word the core is reading now.
    always_comb begin
        w_tgt = r_lru;
        if (r_v[0] && (r_tag[0] == r_addr[31:2])) begin
            w_tgt = 1'b0;
        end else if (r_v[1] && (r_tag[1] == r_addr[31:2])) begin
            w_tgt = 1'b1;
        end else if (w_hit[r_lru]) begin
            w_tgt = ~r_lru;
        end
    end

    assign w_pf_present = r_v[~w_tgt] && (r_tag[~w_tgt] == w_nxt_addr[31:2]);
    assign w_pf_go      = PREFETCH_EN && !w_pf_present;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_issue) w_next = S_REQ_D;
            end
            S_REQ_D: begin
                if (flush)        w_next = S_IDLE;
                else if (mem_gnt) w_next = S_WAIT_D;
            end
            S_WAIT_D: begin
                if (flush)           w_next = S_IDLE;
                else if (mem_rvalid) w_next = w_pf_go ? S_REQ_P : S_IDLE;
            end
            S_REQ_P: begin
                if (flush)           w_next = S_IDLE;
                else if (mem_gnt)    w_next = S_WAIT_P;
                else if (!w_hit_any) w_next = S_IDLE;
            end
            S_WAIT_P: begin
                if (flush || mem_rvalid) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req  = (r_state == S_REQ_D) || (r_state == S_REQ_P);
        mem_addr = r_addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= 32'd0;
            r_miss_cnt <= '0;
            r_drop     <= 1'b0;
        end else begin
            if (w_issue) begin
                r_addr     <= {imem_addr[31:2], 2'b00};
                r_miss_cnt <= r_miss_cnt + 1'b1;
            end else if ((r_state == S_WAIT_D) && w_fill && w_pf_go) begin
                r_addr <= w_nxt_addr;
            end
            // A flushed request still owes one response; swallow it before reissuing.
            if (w_set_drop) begin
                r_drop <= 1'b1;
            end else if (mem_rvalid) begin
                r_drop <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v       <= 2'b00;
            r_lru     <= 1'b0;
            r_tag[0]  <= 30'd0;
            r_tag[1]  <= 30'd0;
            r_data[0] <= 32'd0;
            r_data[1] <= 32'd0;
        end else if (flush) begin
            r_v <= 2'b00;
        end else if (w_fill) begin
            r_v[w_tgt]    <= 1'b1;
            r_tag[w_tgt]  <= r_addr[31:2];
            r_data[w_tgt] <= mem_rdata;
            r_lru         <= ~w_tgt;
        end else if (w_hit[0]) begin
            r_lru <= 1'b1;
        end else if (w_hit[1]) begin
            r_lru <= 1'b0;
        end
    end

endmodule

// File: tb/tb_imem_fetch_buffer.sv
// tb/tb_imem_fetch_buffer.sv - directed vector bench for imem_fetch_buffer.
module tb_imem_fetch_buffer;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        imem_valid;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [15:0] miss_cnt;

    int n_run;
    int n_fail;

    typedef struct {
        logic [31:0] addr;
        bit          fl;
        bit          gnt;
        bit          rv;
        logic [31:0] rdata;
        bit          e_req;
        logic [31:0] e_maddr;
        bit          e_valid;
        logic [31:0] e_data;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs [21];

    imem_fetch_buffer #(
        .PREFETCH_EN(1'b1),
        .CNT_W      (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .imem_valid(imem_valid),
        .flush     (flush),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_gnt   (mem_gnt),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata),
        .miss_cnt  (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input bit e_req, input logic [31:0] e_maddr,
                         input bit e_valid, input logic [31:0] e_data, input logic [15:0] e_cnt);
        n_run++;
        if (mem_req !== e_req || mem_addr !== e_maddr || imem_valid !== e_valid ||
            imem_data !== e_data || miss_cnt !== e_cnt) begin
            n_fail++;
            $display("FAIL %s[%0d]: got req=%0b maddr=%h valid=%0b data=%h cnt=%0d, want req=%0b maddr=%h valid=%0b data=%h cnt=%0d",
                     name, idx, mem_req, mem_addr, imem_valid, imem_data, miss_cnt,
                     e_req, e_maddr, e_valid, e_data, e_cnt);
        end
    endtask

    // One cycle: drive on the falling edge, check mid low phase, the rising edge then acts.
    task automatic step(input string name, input int idx, input vec_t v);
        @(negedge clk);
        rst_n      = 1'b1;
        imem_addr  = v.addr;
        flush      = v.fl;
        mem_gnt    = v.gnt;
        mem_rvalid = v.rv;
        mem_rdata  = v.rdata;
        #2;
        check(name, idx, v.e_req, v.e_maddr, v.e_valid, v.e_data, v.e_cnt);
    endtask

    task automatic hold_reset(input logic [31:0] addr);
        @(negedge clk);
        rst_n      = 1'b0;
        imem_addr  = addr;
        flush      = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        #2;
        check("reset", 0, 1'b0, 32'd0, 1'b0, 32'd0, 16'd0);
    endtask

    function automatic vec_t mk(input logic [31:0] addr, input bit fl, input bit gnt, input bit rv,
                                input logic [31:0] rdata, input bit e_req, input logic [31:0] e_maddr,
                                input bit e_valid, input logic [31:0] e_data, input logic [15:0] e_cnt);
        vec_t v;
        v.addr = addr; v.fl = fl; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
        v.e_req = e_req; v.e_maddr = e_maddr; v.e_valid = e_valid; v.e_data = e_data; v.e_cnt = e_cnt;
        return v;
    endfunction

    initial begin
        n_run  = 0;
        n_fail = 0;
        rst_n      = 1'b0;
        imem_addr  = 32'd0;
        flush      = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;

        // Cold miss, prefetch, jump during WAIT_D, prefetch abort, victim protection.
        vecs[0]  = mk(32'h00, 0, 0, 0, 32'h0,        0, 32'h00, 0, 32'h0,        16'd0);
        vecs[1]  = mk(32'h00, 0, 1, 0, 32'h0,        1, 32'h00, 0, 32'h0,        16'd1);
        vecs[2]  = mk(32'h00, 0, 0, 0, 32'h0,        0, 32'h00, 0, 32'h0,        16'd1);
        vecs[3]  = mk(32'h00, 0, 0, 1, 32'h00500093, 0, 32'h00, 0, 32'h0,        16'd1);
        vecs[4]  = mk(32'h00, 0, 1, 0, 32'h0,        1, 32'h04, 1, 32'h00500093, 16'd1);
        vecs[5]  = mk(32'h00, 0, 0, 1, 32'h00100113, 0, 32'h04, 1, 32'h00500093, 16'd1);
        vecs[6]  = mk(32'h04, 0, 0, 0, 32'h0,        0, 32'h04, 1, 32'h00100113, 16'd1);
        vecs[7]  = mk(32'h08, 0, 0, 0, 32'h0,        0, 32'h04, 0, 32'h0,        16'd1);
        vecs[8]  = mk(32'h08, 0, 1, 0, 32'h0,        1, 32'h08, 0, 32'h0,        16'd2);
        vecs[9]  = mk(32'h40, 0, 0, 0, 32'h0,        0, 32'h08, 0, 32'h0,        16'd2);
        vecs[10] = mk(32'h40, 0, 0, 1, 32'h00008888, 0, 32'h08, 0, 32'h0,        16'd2);
        vecs[11] = mk(32'h40, 0, 0, 0, 32'h0,        1, 32'h0C, 0, 32'h0,        16'd2);
        vecs[12] = mk(32'h40, 0, 0, 0, 32'h0,        0, 32'h0C, 0, 32'h0,        16'd2);
        vecs[13] = mk(32'h40, 0, 1, 0, 32'h0,        1, 32'h40, 0, 32'h0,        16'd3);
        vecs[14] = mk(32'h40, 0, 0, 1, 32'h12345678, 0, 32'h40, 0, 32'h0,        16'd3);
        vecs[15] = mk(32'h40, 0, 0, 0, 32'h0,        1, 32'h44, 1, 32'h12345678, 16'd3);
        vecs[16] = mk(32'h08, 0, 1, 0, 32'h0,        1, 32'h44, 1, 32'h00008888, 16'd3);
        vecs[17] = mk(32'h40, 0, 0, 1, 32'h00004444, 0, 32'h44, 1, 32'h12345678, 16'd3);
        vecs[18] = mk(32'h44, 0, 0, 0, 32'h0,        0, 32'h44, 1, 32'h00004444, 16'd3);
        vecs[19] = mk(32'h40, 0, 0, 0, 32'h0,        0, 32'h44, 1, 32'h12345678, 16'd3);
        vecs[20] = mk(32'h08, 0, 0, 0, 32'h0,        0, 32'h44, 0, 32'h0,        16'd3);

        hold_reset(32'h0);
        for (int i = 0; i < 21; i++) begin
            step("vec", i, vecs[i]);
        end

        // Flush during WAIT_D, then flush of a valid buffer while a prefetch waits for gnt.
        hold_reset(32'h10);
        step("flush", 0, mk(32'h10, 0, 0, 0, 32'h0,        0, 32'h00, 0, 32'h0,        16'd0));
        step("flush", 1, mk(32'h10, 0, 1, 0, 32'h0,        1, 32'h10, 0, 32'h0,        16'd1));
        step("flush", 2, mk(32'h10, 1, 0, 0, 32'h0,        0, 32'h10, 0, 32'h0,        16'd1));
        step("flush", 3, mk(32'h10, 0, 0, 1, 32'hDEADBEEF, 0, 32'h10, 0, 32'h0,        16'd1));
        step("flush", 4, mk(32'h10, 0, 0, 0, 32'h0,        0, 32'h10, 0, 32'h0,        16'd1));
        step("flush", 5, mk(32'h10, 0, 1, 0, 32'h0,        1, 32'h10, 0, 32'h0,        16'd2));
        step("flush", 6, mk(32'h10, 0, 0, 1, 32'h00A00513, 0, 32'h10, 0, 32'h0,        16'd2));
        step("flush", 7, mk(32'h10, 1, 0, 0, 32'h0,        1, 32'h14, 1, 32'h00A00513, 16'd2));
        step("flush", 8, mk(32'h10, 0, 0, 0, 32'h0,        0, 32'h14, 0, 32'h0,        16'd2));
        step("flush", 9, mk(32'h10, 0, 0, 0, 32'h0,        1, 32'h10, 0, 32'h0,        16'd3));

        // Prefetch address wraps past the top of memory, then async reset in WAIT_P.
        hold_reset(32'hFFFFFFFC);
        step("wrap", 0, mk(32'hFFFFFFFC, 0, 0, 0, 32'h0,        0, 32'h00000000, 0, 32'h0,        16'd0));
        step("wrap", 1, mk(32'hFFFFFFFC, 0, 1, 0, 32'h0,        1, 32'hFFFFFFFC, 0, 32'h0,        16'd1));
        step("wrap", 2, mk(32'hFFFFFFFC, 0, 0, 1, 32'h0000006F, 0, 32'hFFFFFFFC, 0, 32'h0,        16'd1));
        step("wrap", 3, mk(32'hFFFFFFFC, 0, 1, 0, 32'h0,        1, 32'h00000000, 1, 32'h0000006F, 16'd1));
        hold_reset(32'hFFFFFFFC);
        step("late_rv", 0, mk(32'h0, 0, 0, 1, 32'h00000BAD, 0, 32'h0, 0, 32'h0, 16'd0));
        step("late_rv", 1, mk(32'h0, 0, 0, 0, 32'h0,        1, 32'h0, 0, 32'h0, 16'd1));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_fetch_buffer.md
Name: imem_fetch_buffer

Overview:
- Instruction-side memory front end sitting directly upstream of the pipelined core's fetch stage; drives the core's imem_data/imem_valid from its imem_addr.
- Holds a 2-entry tagged word buffer, services misses over a req/gnt/rvalid backing-memory port, and optionally prefetches the sequential next word (addr+4).
- A flush input invalidates the buffer after self-modifying code or a fence.i.

Parameters:
- PREFETCH_EN, 1, enables next-word prefetch after each demand fill (0 = demand only).
- CNT_W, 16, width of the performance miss counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- imem_addr  in  32  fetch address from core; bits [1:0] ignored
- imem_data  out  32  instruction word for imem_addr when imem_valid=1, else 0
- imem_valid  out  1  level: buffer holds the word for the current imem_addr
- flush  in  1  invalidate all entries (single-cycle pulse or level)
- mem_req  out  1  backing-memory read request
- mem_addr  out  32  word-aligned request address ([1:0]=0)
- mem_gnt  in  1  request accepted this cycle when mem_req=1
- mem_rvalid  in  1  read data valid (exactly one per granted request, in order)
- mem_rdata  in  32  read data
- miss_cnt  out  CNT_W  demand misses since reset; wraps

Behaviour:
- Reset (async, rst_n=0): both entries invalid, FSM=IDLE, mem_req=0, mem_addr=0, miss_cnt=0, imem_valid=0, imem_data=0. Reset mid-transaction abandons the outstanding request; any later mem_rvalid is ignored until a new request is granted.
- Entry i = {v, tag[29:0]=addr[31:2], data[31:0]}; 1-bit LRU pointer selects the victim.
- Hit = any valid entry with tag==imem_addr[31:2]. imem_valid and imem_data are combinational from the entry registers and imem_addr (zero-cycle on a hit). A hit updates the LRU pointer to the other entry.
- FSM states:
  - IDLE: on miss and flush=0, latch req_addr={imem_addr[31:2],2'b00}, increment miss_cnt, go REQ_D.
  - REQ_D: mem_req=1, mem_addr=req_addr; on mem_gnt go WAIT_D.
  - WAIT_D: on mem_rvalid, write {1,req_addr[31:2],mem_rdata} to the LRU entry and flip LRU. Then:
    - If PREFETCH_EN=1 and req_addr+4 is not present, set pf_addr=req_addr+4 (wraps 0xFFFFFFFC->0x00000000) and go REQ_P.
    - Otherwise go IDLE.
  - REQ_P/WAIT_P: same handshake for pf_addr. Fill on rvalid without touching miss_cnt. Return to IDLE, where a pending demand miss is then issued.
- A demand miss arising during REQ_P/WAIT_P waits; the prefetch is never cancelled on the bus. A prefetch in REQ_P with no gnt yet and a demand miss pending aborts to IDLE (mem_req drops).
- imem_addr changing during WAIT_D (core jump): the response still fills, tagged with req_addr. The FSM then re-evaluates in IDLE.
- Fill victim never evicts the entry matching the current imem_addr. If the LRU points at it, the other entry is used.
- Filling a tag already present overwrites that entry rather than the LRU entry.
- Flush (edge where flush=1): all v cleared, imem_valid=0 next cycle. If a request is outstanding, a drop flag is set, the response is discarded, and the FSM returns to IDLE. Flush has priority over a same-cycle fill.
- Once a request is granted, mem_req deasserts the following cycle; at most one request is outstanding. mem_req held high until mem_gnt, with mem_addr stable.
- Demand latency: addr presented in cycle 0, mem_req high in cycle 1. With gnt in cycle 1 and rvalid in cycle 1+L, imem_valid rises in cycle 2+L.

Test Plan:
- Cold miss: reset, imem_addr=0x00000000, memory gnt same cycle, rvalid 2 cycles later, word 0x00500093 -> mem_req high cycle 1, imem_valid=1 with imem_data=0x00500093 in cycle 4, miss_cnt=1.
- Sequential prefetch: after the cold miss (PREFETCH_EN=1), mem_addr=0x00000004 issued. Core moves to 0x4 once filled -> imem_valid=1 in the same cycle as the address change, miss_cnt stays 1.
- Jump during outstanding demand: imem_addr changes 0x8->0x40 while in WAIT_D -> 0x8 fill completes, then demand for 0x40 is issued, miss_cnt=2, imem_valid only once data for 0x40 returns.
- Flush mid-request: flush pulse during WAIT_D for 0x10 -> response discarded, imem_valid=0, FSM re-issues 0x10, miss_cnt increments again.
- Wrap: demand at 0xFFFFFFFC -> prefetch mem_addr=0x00000000.
- Async reset mid-WAIT_P: rst_n low -> mem_req=0, imem_valid=0, miss_cnt=0 immediately. A late rvalid after release does not set imem_valid.
